// File: rtl/lc3_ctrl_pkg.sv
// Shared types and encodings for the SLC-3 instruction sequencer.
// Holds the FSM state enum, opcode constants, datapath mux/ALU encodings and the wait-timer width.
package lc3_ctrl_pkg;

    localparam int unsigned WAIT_W = 4;

    typedef enum logic [4:0] {
        S_HALTED,
        S_FETCH1,
        S_FETCH2,
        S_FETCH3,
        S_DECODE,
        S_ALU,
        S_BR0,
        S_BR1,
        S_JMP,
        S_JSR0,
        S_JSR1,
        S_LDR0,
        S_LDR1,
        S_LDR2,
        S_STR0,
        S_STR1,
        S_STR2,
        S_P1,
        S_P2
    } state_t;

    localparam logic [3:0] OP_BR    = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_JSR   = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_LDR   = 4'b0110;
    localparam logic [3:0] OP_STR   = 4'b0111;
    localparam logic [3:0] OP_NOT   = 4'b1001;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_PAUSE = 4'b1101;

    localparam logic [1:0] PCMUX_INC   = 2'b00;
    localparam logic [1:0] PCMUX_ADDER = 2'b10;

    localparam logic [1:0] ADDR2_ZERO   = 2'b00;
    localparam logic [1:0] ADDR2_SEXT6  = 2'b01;
    localparam logic [1:0] ADDR2_SEXT9  = 2'b10;
    localparam logic [1:0] ADDR2_SEXT11 = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_AND   = 2'b01;
    localparam logic [1:0] ALU_NOT   = 2'b10;
    localparam logic [1:0] ALU_PASSA = 2'b11;

endpackage

// File: rtl/mem_wait_timer.sv
// Down-counter that stretches an SRAM access to MEM_WAIT cycles.
// Loaded on the cycle before a memory state; o_done_c is high on the final cycle of the access.
import lc3_ctrl_pkg::*;

module mem_wait_timer #(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    input  logic i_dec,
    output logic o_done_c
);

    logic [WAIT_W-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= WAIT_W'(MEM_WAIT - 1);
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - WAIT_W'(1);
        end
    end

    assign o_done_c = (r_count == '0);

endmodule

// File: rtl/lc3_instr_sequencer.sv
// Moore fetch/decode/execute control FSM for the SLC-3 datapath.
// All datapath controls are decoded from the current state (SR2MUX/ALUK also look at IR).
import lc3_ctrl_pkg::*;

module lc3_instr_sequencer #(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Run,
    input  logic        Continue,
    input  logic [15:0] IR,
    input  logic        BEN,
    output logic        LD_MAR,
    output logic        LD_MDR,
    output logic        LD_IR,
    output logic        LD_BEN,
    output logic        LD_CC,
    output logic        LD_REG,
    output logic        LD_PC,
    output logic        LD_LED,
    output logic        GatePC,
    output logic        GateMDR,
    output logic        GateALU,
    output logic        GateMARMUX,
    output logic [1:0]  PCMUX,
    output logic        DRMUX,
    output logic        SR1MUX,
    output logic        SR2MUX,
    output logic        ADDR1MUX,
    output logic [1:0]  ADDR2MUX,
    output logic [1:0]  ALUK,
    output logic        MIO_EN,
    output logic        Mem_OE,
    output logic        Mem_WE
);

    state_t r_state;
    state_t w_next;
    logic   w_load;
    logic   w_dec;
    logic   w_done;
    logic   w_unused_ir;

    assign w_unused_ir = &{1'b0, IR[10:6], IR[4:0]};

    mem_wait_timer #(.MEM_WAIT(MEM_WAIT)) u_timer (
        .i_clk    (Clk),
        .i_rst    (Reset),
        .i_load   (w_load),
        .i_dec    (w_dec),
        .o_done_c (w_done)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_HALTED;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_dec      = 1'b0;
        LD_MAR     = 1'b0;
        LD_MDR     = 1'b0;
        LD_IR      = 1'b0;
        LD_BEN     = 1'b0;
        LD_CC      = 1'b0;
        LD_REG     = 1'b0;
        LD_PC      = 1'b0;
        LD_LED     = 1'b0;
        GatePC     = 1'b0;
        GateMDR    = 1'b0;
        GateALU    = 1'b0;
        GateMARMUX = 1'b0;
        PCMUX      = PCMUX_INC;
        DRMUX      = 1'b0;
        SR1MUX     = 1'b0;
        SR2MUX     = 1'b0;
        ADDR1MUX   = 1'b0;
        ADDR2MUX   = ADDR2_ZERO;
        ALUK       = ALU_ADD;
        MIO_EN     = 1'b0;
        Mem_OE     = 1'b0;
        Mem_WE     = 1'b0;
        case (r_state)
            S_HALTED: if (Run) w_next = S_FETCH1;
            S_FETCH1: begin
                GatePC = 1'b1;
                LD_MAR = 1'b1;
                LD_PC  = 1'b1;
                w_load = 1'b1;
                w_next = S_FETCH2;
            end
            S_FETCH2: begin
                Mem_OE = 1'b1;
                MIO_EN = 1'b1;
                LD_MDR = w_done;
                w_dec  = 1'b1;
                if (w_done) w_next = S_FETCH3;
            end
            S_FETCH3: begin
                GateMDR = 1'b1;
                LD_IR   = 1'b1;
                w_next  = S_DECODE;
            end
            S_DECODE: begin
                LD_BEN = 1'b1;
                case (IR[15:12])
                    OP_ADD, OP_AND, OP_NOT: w_next = S_ALU;
                    OP_BR:    w_next = S_BR0;
                    OP_JMP:   w_next = S_JMP;
                    OP_JSR:   w_next = IR[11] ? S_JSR0 : S_FETCH1;
                    OP_LDR:   w_next = S_LDR0;
                    OP_STR:   w_next = S_STR0;
                    OP_PAUSE: w_next = S_P1;
                    default:  w_next = S_FETCH1;
                endcase
            end
            S_ALU: begin
                SR1MUX  = 1'b1;
                SR2MUX  = IR[5];
                GateALU = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
                case (IR[15:12])
                    OP_AND:  ALUK = ALU_AND;
                    OP_NOT:  ALUK = ALU_NOT;
                    default: ALUK = ALU_ADD;
                endcase
                w_next = S_FETCH1;
            end
            S_BR0: w_next = BEN ? S_BR1 : S_FETCH1;
            S_BR1: begin
                ADDR2MUX = ADDR2_SEXT9;
                PCMUX    = PCMUX_ADDER;
                LD_PC    = 1'b1;
                w_next   = S_FETCH1;
            end
            S_JMP: begin
                SR1MUX   = 1'b1;
                ADDR1MUX = 1'b1;
                ADDR2MUX = ADDR2_ZERO;
                PCMUX    = PCMUX_ADDER;
                LD_PC    = 1'b1;
                w_next   = S_FETCH1;
            end
            // R7 <= PC first, then PC <= PC + SEXT11
            S_JSR0: begin
                DRMUX  = 1'b1;
                GatePC = 1'b1;
                LD_REG = 1'b1;
                w_next = S_JSR1;
            end
            S_JSR1: begin
                ADDR2MUX = ADDR2_SEXT11;
                PCMUX    = PCMUX_ADDER;
                LD_PC    = 1'b1;
                w_next   = S_FETCH1;
            end
            S_LDR0, S_STR0: begin
                SR1MUX     = 1'b1;
                ADDR1MUX   = 1'b1;
                ADDR2MUX   = ADDR2_SEXT6;
                GateMARMUX = 1'b1;
                LD_MAR     = 1'b1;
                w_load     = (r_state == S_LDR0);
                w_next     = (r_state == S_LDR0) ? S_LDR1 : S_STR1;
            end
            S_LDR1: begin
                Mem_OE = 1'b1;
                MIO_EN = 1'b1;
                LD_MDR = w_done;
                w_dec  = 1'b1;
                if (w_done) w_next = S_LDR2;
            end
            S_LDR2: begin
                GateMDR = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
                w_next  = S_FETCH1;
            end
            // Source register passes through the ALU into MDR
            S_STR1: begin
                ALUK    = ALU_PASSA;
                GateALU = 1'b1;
                LD_MDR  = 1'b1;
                w_load  = 1'b1;
                w_next  = S_STR2;
            end
            S_STR2: begin
                Mem_WE = 1'b1;
                w_dec  = 1'b1;
                if (w_done) w_next = S_FETCH1;
            end
            S_P1: begin
                LD_LED = 1'b1;
                if (Continue) w_next = S_P2;
            end
            S_P2: if (!Continue) w_next = S_FETCH1;
            default: w_next = S_HALTED;
        endcase
    end

endmodule

// File: tb/tb_lc3_instr_sequencer.sv
// Directed bench for lc3_instr_sequencer: MEM_WAIT=2 instance for the main flows,
// MEM_WAIT=3 instance for the store path.
module tb_lc3_instr_sequencer;

    localparam logic [24:0] X_LD_MAR   = 25'h0000001;
    localparam logic [24:0] X_LD_MDR   = 25'h0000002;
    localparam logic [24:0] X_LD_IR    = 25'h0000004;
    localparam logic [24:0] X_LD_BEN   = 25'h0000008;
    localparam logic [24:0] X_LD_CC    = 25'h0000010;
    localparam logic [24:0] X_LD_REG   = 25'h0000020;
    localparam logic [24:0] X_LD_PC    = 25'h0000040;
    localparam logic [24:0] X_LD_LED   = 25'h0000080;
    localparam logic [24:0] X_GPC      = 25'h0000100;
    localparam logic [24:0] X_GMDR     = 25'h0000200;
    localparam logic [24:0] X_GALU     = 25'h0000400;
    localparam logic [24:0] X_GMARMUX  = 25'h0000800;
    localparam logic [24:0] X_PC_ADDER = 25'h0002000;
    localparam logic [24:0] X_DRMUX    = 25'h0004000;
    localparam logic [24:0] X_SR1MUX   = 25'h0008000;
    localparam logic [24:0] X_SR2MUX   = 25'h0010000;
    localparam logic [24:0] X_ADDR1    = 25'h0020000;
    localparam logic [24:0] X_SEXT6    = 25'h0040000;
    localparam logic [24:0] X_SEXT9    = 25'h0080000;
    localparam logic [24:0] X_SEXT11   = 25'h00C0000;
    localparam logic [24:0] X_AND      = 25'h0100000;
    localparam logic [24:0] X_NOT      = 25'h0200000;
    localparam logic [24:0] X_PASSA    = 25'h0300000;
    localparam logic [24:0] X_MIO      = 25'h0400000;
    localparam logic [24:0] X_OE       = 25'h0800000;
    localparam logic [24:0] X_WE       = 25'h1000000;

    localparam logic [24:0] E_FETCH1 = X_GPC | X_LD_MAR | X_LD_PC;
    localparam logic [24:0] E_RD     = X_OE | X_MIO;
    localparam logic [24:0] E_RDLAST = X_OE | X_MIO | X_LD_MDR;
    localparam logic [24:0] E_FETCH3 = X_GMDR | X_LD_IR;
    localparam logic [24:0] E_MARC   = X_SR1MUX | X_ADDR1 | X_SEXT6 | X_GMARMUX | X_LD_MAR;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Run = 1'b0;
    logic        Continue = 1'b0;
    logic [15:0] IR = 16'h0000;
    logic        BEN = 1'b0;
    logic        b_Reset = 1'b1;
    logic        b_Run = 1'b0;
    logic [24:0] a_out;
    logic [24:0] b_out;
    int          checks = 0;
    int          errors = 0;
    int          viol = 0;

    always #5 Clk = ~Clk;

    lc3_instr_sequencer #(.MEM_WAIT(2)) dut_a (
        .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue), .IR(IR), .BEN(BEN),
        .LD_MAR(a_out[0]), .LD_MDR(a_out[1]), .LD_IR(a_out[2]), .LD_BEN(a_out[3]),
        .LD_CC(a_out[4]), .LD_REG(a_out[5]), .LD_PC(a_out[6]), .LD_LED(a_out[7]),
        .GatePC(a_out[8]), .GateMDR(a_out[9]), .GateALU(a_out[10]), .GateMARMUX(a_out[11]),
        .PCMUX(a_out[13:12]), .DRMUX(a_out[14]), .SR1MUX(a_out[15]), .SR2MUX(a_out[16]),
        .ADDR1MUX(a_out[17]), .ADDR2MUX(a_out[19:18]), .ALUK(a_out[21:20]),
        .MIO_EN(a_out[22]), .Mem_OE(a_out[23]), .Mem_WE(a_out[24])
    );

    lc3_instr_sequencer #(.MEM_WAIT(3)) dut_b (
        .Clk(Clk), .Reset(b_Reset), .Run(b_Run), .Continue(Continue), .IR(IR), .BEN(BEN),
        .LD_MAR(b_out[0]), .LD_MDR(b_out[1]), .LD_IR(b_out[2]), .LD_BEN(b_out[3]),
        .LD_CC(b_out[4]), .LD_REG(b_out[5]), .LD_PC(b_out[6]), .LD_LED(b_out[7]),
        .GatePC(b_out[8]), .GateMDR(b_out[9]), .GateALU(b_out[10]), .GateMARMUX(b_out[11]),
        .PCMUX(b_out[13:12]), .DRMUX(b_out[14]), .SR1MUX(b_out[15]), .SR2MUX(b_out[16]),
        .ADDR1MUX(b_out[17]), .ADDR2MUX(b_out[19:18]), .ALUK(b_out[21:20]),
        .MIO_EN(b_out[22]), .Mem_OE(b_out[23]), .Mem_WE(b_out[24])
    );

    // Bus-gate one-hot and strobe exclusivity on both instances, every cycle
    always @(negedge Clk) begin
        if ($countones(a_out[11:8]) > 1 || $countones(b_out[11:8]) > 1) viol++;
        if ((a_out[23] && a_out[24]) || (b_out[23] && b_out[24])) viol++;
        if ((a_out[1] && a_out[24]) || (b_out[1] && b_out[24])) viol++;
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [24:0] obs, input logic [24:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // From FETCH1 on dut_a: two read cycles, FETCH3, DECODE
    task automatic fetch_a(input string tag);
        step(); chk({tag, "_rd1"}, a_out, E_RD);
        step(); chk({tag, "_rd2"}, a_out, E_RDLAST);
        step(); chk({tag, "_f3"}, a_out, E_FETCH3);
        step(); chk({tag, "_dec"}, a_out, X_LD_BEN);
    endtask

    initial begin
        #1;
        chk("reset_out", a_out, 25'h0);
        step(); step();
        Reset = 1'b0;
        chk("halted", a_out, 25'h0);
        step();
        chk("halted_norun", a_out, 25'h0);

        // ADD R1,R2,R3
        IR = 16'h1283; Run = 1'b1;
        step(); chk("add_f1", a_out, E_FETCH1);
        Run = 1'b0;
        fetch_a("add");
        step(); chk("add_exec", a_out, X_SR1MUX | X_GALU | X_LD_REG | X_LD_CC);
        step(); chk("add_back_f1", a_out, E_FETCH1);

        // AND immediate and NOT
        IR = 16'h5262;
        fetch_a("and");
        step(); chk("and_exec", a_out, X_SR1MUX | X_SR2MUX | X_AND | X_GALU | X_LD_REG | X_LD_CC);
        step(); chk("and_f1", a_out, E_FETCH1);
        IR = 16'h927F;
        fetch_a("not");
        step(); chk("not_exec", a_out, X_SR1MUX | X_SR2MUX | X_NOT | X_GALU | X_LD_REG | X_LD_CC);
        step(); chk("not_f1", a_out, E_FETCH1);

        // BRnzp taken / not taken
        IR = 16'h0E05; BEN = 1'b1;
        fetch_a("brt");
        step(); chk("brt_br0", a_out, 25'h0);
        step(); chk("brt_br1", a_out, X_SEXT9 | X_PC_ADDER | X_LD_PC);
        step(); chk("brt_f1", a_out, E_FETCH1);
        BEN = 1'b0;
        fetch_a("brn");
        step(); chk("brn_br0", a_out, 25'h0);
        step(); chk("brn_f1", a_out, E_FETCH1);

        // JMP R2
        IR = 16'hC080;
        fetch_a("jmp");
        step(); chk("jmp_exec", a_out, X_SR1MUX | X_ADDR1 | X_PC_ADDER | X_LD_PC);
        step(); chk("jmp_f1", a_out, E_FETCH1);

        // JSR, then unsupported JSRR
        IR = 16'h4803;
        fetch_a("jsr");
        step(); chk("jsr0", a_out, X_DRMUX | X_GPC | X_LD_REG);
        step(); chk("jsr1", a_out, X_SEXT11 | X_PC_ADDER | X_LD_PC);
        step(); chk("jsr_f1", a_out, E_FETCH1);
        IR = 16'h4080;
        fetch_a("jsrr");
        step(); chk("jsrr_f1", a_out, E_FETCH1);

        // Unused opcode does nothing
        IR = 16'hF025;
        fetch_a("trap");
        step(); chk("trap_f1", a_out, E_FETCH1);

        // PAUSE handshake; Run toggling must be ignored here
        IR = 16'hD000; Continue = 1'b0;
        fetch_a("pause");
        for (int i = 0; i < 10; i++) begin
            Run = i[0];
            step(); chk("pause_p1", a_out, X_LD_LED);
        end
        Run = 1'b0; Continue = 1'b1;
        step(); chk("pause_p2a", a_out, 25'h0);
        step(); chk("pause_p2b", a_out, 25'h0);
        Continue = 1'b0;
        step(); chk("pause_f1", a_out, E_FETCH1);

        // Full LDR
        IR = 16'h6284;
        fetch_a("ldr");
        step(); chk("ldr0", a_out, E_MARC);
        step(); chk("ldr1_a", a_out, E_RD);
        step(); chk("ldr1_b", a_out, E_RDLAST);
        step(); chk("ldr2", a_out, X_GMDR | X_LD_REG | X_LD_CC);
        step(); chk("ldr_f1", a_out, E_FETCH1);

        // LDR interrupted by Reset in its second wait cycle
        fetch_a("ldrr");
        step(); chk("ldrr0", a_out, E_MARC);
        step(); chk("ldrr1_a", a_out, E_RD);
        step(); chk("ldrr1_b", a_out, E_RDLAST);
        Reset = 1'b1;
        #1; chk("mid_reset", a_out, 25'h0);
        step(); Reset = 1'b0;
        step(); chk("post_reset_a", a_out, 25'h0);
        step(); chk("post_reset_b", a_out, 25'h0);
        Run = 1'b1;
        step(); chk("rerun_f1", a_out, E_FETCH1);
        Run = 1'b0;
        fetch_a("rerun");

        // STR on the MEM_WAIT=3 instance
        Reset = 1'b1;
        IR = 16'h7284; b_Reset = 1'b0; b_Run = 1'b1;
        step(); chk("str_f1", b_out, E_FETCH1);
        b_Run = 1'b0;
        step(); chk("str_rd1", b_out, E_RD);
        step(); chk("str_rd2", b_out, E_RD);
        step(); chk("str_rd3", b_out, E_RDLAST);
        step(); chk("str_f3", b_out, E_FETCH3);
        step(); chk("str_dec", b_out, X_LD_BEN);
        step(); chk("str0", b_out, E_MARC);
        step(); chk("str1", b_out, X_PASSA | X_GALU | X_LD_MDR);
        step(); chk("str2_a", b_out, X_WE);
        step(); chk("str2_b", b_out, X_WE);
        step(); chk("str2_c", b_out, X_WE);
        step(); chk("str_f1_back", b_out, E_FETCH1);

        checks++;
        assert (viol === 0)
        else begin
            errors++;
            $error("FAIL invariants observed %0d expected 0", viol);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
